// File: rtl/dp_ram_pkg.sv
// Shared types and helpers for the dual-port byte-enable RAM with zero-fill.
// Contents: zero-fill FSM state enum, clog2, lane_merge, read-mode constants.
package dp_ram_pkg;

  localparam int unsigned RD_FIRST = 0;
  localparam int unsigned WR_FIRST = 1;

  // Upper bounds for the width-generic lane_merge helper.
  localparam int unsigned MAX_W  = 1024;
  localparam int unsigned MAX_NB = MAX_W / 8;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  // Replace the byte lanes of old_w selected by be with those of new_w.
  function automatic logic [MAX_W-1:0] lane_merge(input logic [MAX_W-1:0]  old_w,
                                                  input logic [MAX_W-1:0]  new_w,
                                                  input logic [MAX_NB-1:0] be);
    logic [MAX_W-1:0] m;
    m = old_w;
    for (int i = 0; i < int'(MAX_NB); i++) begin
      if (be[i]) m[8*i +: 8] = new_w[8*i +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/dp_ram_clr_fsm.sv
// Zero-fill sequencer: walks the word index from 0 to DEPTH-1, one word per cycle.
// Ports: clk, rst (sync, active high), clr_req (start pulse),
//        busy (fill in progress), clr_we (clear write strobe), clr_idx (word to clear).
module dp_ram_clr_fsm
  import dp_ram_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned CLR_ON_RST = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_req,
  output logic                  busy,
  output logic                  clr_we,
  output logic [DEPTH_LOG2-1:0] clr_idx
);

  // One spare counter bit keeps the terminal index distinct from a wrapped zero.
  localparam int unsigned   CW   = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] LAST = CW'((64'd1 << DEPTH_LOG2) - 64'd1);

  clr_state_e    state;
  logic [CW-1:0] cnt;

  // State, counter and busy flag; busy mirrors the CLEAR state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= (CLR_ON_RST != 0) ? CLEAR : IDLE;
      cnt   <= '0;
      busy  <= (CLR_ON_RST != 0);
    end else begin
      case (state)
        IDLE: begin
          if (clr_req) begin
            state <= CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          if (cnt == LAST) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign clr_we  = busy;
  assign clr_idx = cnt[DEPTH_LOG2-1:0];

endmodule

// File: rtl/dp_byte_ram_clr.sv
// True dual-port synchronous RAM with byte write enables, range check,
// selectable read-during-write mode, optional output register and zero-fill.
// Ports: clk, rst, clr_req, busy;
//        port A (CPU): wea, addra, dina, douta, erra;
//        port B (debug): web, addrb, dinb, doutb, errb.
module dp_byte_ram_clr
  import dp_ram_pkg::*;
#(
  parameter  int unsigned DATA_W     = 32,
  parameter  int unsigned DEPTH_LOG2 = 12,
  parameter  int unsigned ADDR_W     = 32,
  parameter  int unsigned BASE       = 0,
  parameter  int unsigned READ_MODE  = 0,
  parameter  int unsigned OUT_REG    = 0,
  parameter  int unsigned CLR_ON_RST = 1,
  localparam int unsigned NB         = DATA_W / 8,
  localparam int unsigned OFF        = clog2(NB),
  localparam int unsigned AW         = ADDR_W - OFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              busy,
  input  logic [NB-1:0]     wea,
  input  logic [AW-1:0]     addra,
  input  logic [DATA_W-1:0] dina,
  output logic [DATA_W-1:0] douta,
  output logic              erra,
  input  logic [NB-1:0]     web,
  input  logic [AW-1:0]     addrb,
  input  logic [DATA_W-1:0] dinb,
  output logic [DATA_W-1:0] doutb,
  output logic              errb
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned UW    = AW - DEPTH_LOG2;

  logic [DATA_W-1:0] mem [DEPTH];

  logic                  clr_we;
  logic [DEPTH_LOG2-1:0] clr_idx;

  logic                  va, vb;
  logic [DEPTH_LOG2-1:0] ia, ib;

  logic [NB-1:0]         we_a_c, we_b_c;
  logic [DEPTH_LOG2-1:0] widx_a_c;
  logic [DATA_W-1:0]     wdat_a_c;

  logic [DATA_W-1:0]     q1_a, q1_b;
  logic                  e1_a, e1_b;

  dp_ram_clr_fsm #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .CLR_ON_RST (CLR_ON_RST)
  ) u_clr_fsm (
    .clk     (clk),
    .rst     (rst),
    .clr_req (clr_req),
    .busy    (busy),
    .clr_we  (clr_we),
    .clr_idx (clr_idx)
  );

  // Range check against BASE and word index extraction.
  assign va = (addra[AW-1:DEPTH_LOG2] == UW'(BASE));
  assign vb = (addrb[AW-1:DEPTH_LOG2] == UW'(BASE));
  assign ia = addra[DEPTH_LOG2-1:0];
  assign ib = addrb[DEPTH_LOG2-1:0];

  // Write-path mux: the fill engine owns port A while busy; user writes are dropped.
  always_comb begin
    we_a_c   = '0;
    widx_a_c = ia;
    wdat_a_c = dina;
    we_b_c   = '0;
    if (clr_we) begin
      we_a_c   = '1;
      widx_a_c = clr_idx;
      wdat_a_c = '0;
    end else begin
      if (va) we_a_c = wea;
      if (vb) we_b_c = web;
    end
  end

  // Storage; port A is applied last so it owns overlapping lanes on a collision.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(NB); i++) begin
      if (we_b_c[i]) mem[ib][8*i +: 8] <= dinb[8*i +: 8];
      if (we_a_c[i]) mem[widx_a_c][8*i +: 8] <= wdat_a_c[8*i +: 8];
    end
  end

  // First read stage: nonblocking reads see the pre-write word (cross-port is always old).
  always_ff @(posedge clk) begin
    if (rst) begin
      q1_a <= '0;
      q1_b <= '0;
      e1_a <= 1'b0;
      e1_b <= 1'b0;
    end else begin
      e1_a <= !busy && !va;
      e1_b <= !busy && !vb;
      if (busy || !va)
        q1_a <= '0;
      else if (READ_MODE == RD_FIRST)
        q1_a <= mem[ia];
      else
        q1_a <= DATA_W'(lane_merge(MAX_W'(mem[ia]), MAX_W'(dina), MAX_NB'(wea)));
      if (busy || !vb)
        q1_b <= '0;
      else if (READ_MODE == RD_FIRST)
        q1_b <= mem[ib];
      else
        q1_b <= DATA_W'(lane_merge(MAX_W'(mem[ib]), MAX_W'(dinb), MAX_NB'(web)));
    end
  end

  // Optional second output stage.
  if (OUT_REG != 0) begin : g_oreg
    always_ff @(posedge clk) begin
      if (rst) begin
        douta <= '0;
        doutb <= '0;
        erra  <= 1'b0;
        errb  <= 1'b0;
      end else begin
        douta <= q1_a;
        doutb <= q1_b;
        erra  <= e1_a;
        errb  <= e1_b;
      end
    end
  end else begin : g_noreg
    assign douta = q1_a;
    assign doutb = q1_b;
    assign erra  = e1_a;
    assign errb  = e1_b;
  end

endmodule

// File: tb/tb_dp_byte_ram_clr.sv
// Self-checking bench: three DUT instances (read-first, write-first, output-registered)
// share one stimulus stream and are compared with a word-array reference model.
module tb_dp_byte_ram_clr;

  localparam int unsigned DW    = 32;
  localparam int unsigned DL    = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned PW    = 30;
  localparam int unsigned UW    = PW - DL;
  localparam int unsigned BASE  = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr_req = 1'b0;
  logic [3:0]    wea = '0, web = '0;
  logic [PW-1:0] addra = '0, addrb = '0;
  logic [DW-1:0] dina = '0, dinb = '0;

  logic [DW-1:0] douta_r, doutb_r, douta_w, doutb_w, douta_o, doutb_o;
  logic          erra_r, errb_r, erra_w, errb_w, erra_o, errb_o;
  logic          busy_r, busy_w, busy_o;

  int checks = 0;
  int fails  = 0;

  // Reference model state.
  logic [DW-1:0] mem_m [DEPTH];
  bit            mbusy = 1'b0;
  int            mcnt  = 0;
  logic [DW-1:0] e1a_rf = '0, e1a_wf = '0, e1b_rf = '0, e1b_wf = '0, e2a = '0, e2b = '0;
  logic          e1ea = 1'b0, e1eb = 1'b0, e2ea = 1'b0, e2eb = 1'b0;

  always #5 clk = ~clk;

  dp_byte_ram_clr #(.DATA_W(DW), .DEPTH_LOG2(DL), .ADDR_W(32), .BASE(BASE),
                    .READ_MODE(0), .OUT_REG(0), .CLR_ON_RST(1)) u_rf (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_r),
    .wea(wea), .addra(addra), .dina(dina), .douta(douta_r), .erra(erra_r),
    .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb_r), .errb(errb_r));

  dp_byte_ram_clr #(.DATA_W(DW), .DEPTH_LOG2(DL), .ADDR_W(32), .BASE(BASE),
                    .READ_MODE(1), .OUT_REG(0), .CLR_ON_RST(1)) u_wf (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_w),
    .wea(wea), .addra(addra), .dina(dina), .douta(douta_w), .erra(erra_w),
    .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb_w), .errb(errb_w));

  dp_byte_ram_clr #(.DATA_W(DW), .DEPTH_LOG2(DL), .ADDR_W(32), .BASE(BASE),
                    .READ_MODE(0), .OUT_REG(1), .CLR_ON_RST(1)) u_or (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_o),
    .wea(wea), .addra(addra), .dina(dina), .douta(douta_o), .erra(erra_o),
    .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb_o), .errb(errb_o));

  function automatic logic [PW-1:0] mk_addr(input bit ok, input int idx);
    logic [UW-1:0] up;
    up = ok ? UW'(BASE) : UW'(BASE + 1 + $urandom_range(0, 100));
    return {up, DL'(idx)};
  endfunction

  // One clock edge: advance the reference model with the inputs present at the edge.
  task automatic step();
    bit            sb, va, vb;
    int            ia, ib;
    logic [DW-1:0] na_rf, na_wf, nb_rf, nb_wf;
    @(posedge clk);
    sb = mbusy;
    va = (addra[PW-1:DL] == UW'(BASE));
    vb = (addrb[PW-1:DL] == UW'(BASE));
    ia = int'(addra[DL-1:0]);
    ib = int'(addrb[DL-1:0]);
    na_rf = '0; na_wf = '0; nb_rf = '0; nb_wf = '0;
    if (!sb && va) begin
      na_rf = mem_m[ia];
      na_wf = na_rf;
      for (int l = 0; l < 4; l++) if (wea[l]) na_wf[8*l +: 8] = dina[8*l +: 8];
    end
    if (!sb && vb) begin
      nb_rf = mem_m[ib];
      nb_wf = nb_rf;
      for (int l = 0; l < 4; l++) if (web[l]) nb_wf[8*l +: 8] = dinb[8*l +: 8];
    end
    if (sb) begin
      mem_m[mcnt] = '0;
    end else begin
      if (vb) for (int l = 0; l < 4; l++) if (web[l]) mem_m[ib][8*l +: 8] = dinb[8*l +: 8];
      if (va) for (int l = 0; l < 4; l++) if (wea[l]) mem_m[ia][8*l +: 8] = dina[8*l +: 8];
    end
    if (rst) begin
      mbusy = 1'b1; mcnt = 0;
    end else if (mbusy) begin
      if (mcnt == DEPTH - 1) mbusy = 1'b0; else mcnt++;
    end else if (clr_req) begin
      mbusy = 1'b1; mcnt = 0;
    end
    if (rst) begin
      e1a_rf = '0; e1a_wf = '0; e1b_rf = '0; e1b_wf = '0; e2a = '0; e2b = '0;
      e1ea = 1'b0; e1eb = 1'b0; e2ea = 1'b0; e2eb = 1'b0;
    end else begin
      e2a = e1a_rf; e2b = e1b_rf; e2ea = e1ea; e2eb = e1eb;
      e1a_rf = na_rf; e1a_wf = na_wf; e1b_rf = nb_rf; e1b_wf = nb_wf;
      e1ea = !sb && !va; e1eb = !sb && !vb;
    end
    #1;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    step(); step();
    checks++;
    if ({douta_r, doutb_r, douta_o, doutb_o, erra_r, errb_r, erra_o, errb_o, busy_r} !==
        {128'h0, 4'h0, 1'b1}) begin
      fails++;
      $display("FAIL reset_state: got da=%h db=%h err=%b%b busy=%b, want zeros and busy=1",
               douta_r, doutb_r, erra_r, errb_r, busy_r);
    end
    rst = 1'b0;
    n = 1;
    for (int i = 0; i < 40 && busy_r; i++) begin
      step();
      if (busy_r) n++;
    end
    checks++;
    if (n !== 16) begin
      fails++;
      $display("FAIL reset_fill_len: busy high %0d cycles, want 16", n);
    end
    for (int i = 0; i < 16; i++) begin
      addra = mk_addr(1, i);
      addrb = mk_addr(1, 15 - i);
      step();
      checks++;
      if ({douta_r, doutb_r, erra_r, errb_r} !== {64'h0, 2'b00}) begin
        fails++;
        $display("FAIL cleared_word_%0d: got a=%h b=%h err=%b%b, want 0", i, douta_r, doutb_r,
                 erra_r, errb_r);
      end
    end
  endtask

  task automatic test_byte_write();
    addra = mk_addr(1, 3); wea = 4'hF; dina = 32'hDEADBEEF; step();
    wea = 4'b0010; dina = 32'h00005500; step();
    wea = 4'h0; step();
    checks++;
    if (douta_r !== 32'hDEAD55EF) begin
      fails++;
      $display("FAIL byte_write_lat1: got %h, want deadbeef-merged dead55ef", douta_r);
    end
    step();
    checks++;
    if (douta_o !== 32'hDEAD55EF) begin
      fails++;
      $display("FAIL byte_write_lat2: got %h, want dead55ef", douta_o);
    end
  endtask

  task automatic test_collision();
    addra = mk_addr(1, 5); addrb = mk_addr(1, 5);
    wea = 4'b0011; dina = 32'h11112222;
    web = 4'b0110; dinb = 32'h33334444;
    step();
    wea = 4'h0; web = 4'h0; step();
    checks++;
    if (douta_r !== 32'h00332222 || doutb_r !== 32'h00332222) begin
      fails++;
      $display("FAIL collision: got a=%h b=%h, want 00332222", douta_r, doutb_r);
    end
  endtask

  task automatic test_rdw();
    addra = mk_addr(1, 7); wea = 4'hF; dina = 32'hAAAAAAAA; step();
    addrb = mk_addr(1, 7); web = 4'h0; dina = 32'h55555555; step();
    checks++;
    if ({douta_r, douta_w, doutb_r, doutb_w} !==
        {32'hAAAAAAAA, 32'h55555555, 32'hAAAAAAAA, 32'hAAAAAAAA}) begin
      fails++;
      $display("FAIL read_during_write: got rf=%h wf=%h brf=%h bwf=%h, want aaaaaaaa 55555555 aaaaaaaa aaaaaaaa",
               douta_r, douta_w, doutb_r, doutb_w);
    end
    wea = 4'h0; step();
    checks++;
    if (douta_r !== 32'h55555555) begin
      fails++;
      $display("FAIL rdw_commit: got %h, want 55555555", douta_r);
    end
  endtask

  task automatic test_range();
    addrb = mk_addr(0, 3); web = 4'hF; dinb = 32'h12345678; step();
    web = 4'h0;
    checks++;
    if (doutb_r !== 32'h0 || errb_r !== 1'b1) begin
      fails++;
      $display("FAIL range_err: got b=%h errb=%b, want 0 and 1", doutb_r, errb_r);
    end
    addrb = mk_addr(1, 3); step();
    checks++;
    if ({doutb_r, errb_r, doutb_o, errb_o} !== {32'hDEAD55EF, 1'b0, 32'h0, 1'b1}) begin
      fails++;
      $display("FAIL range_drop: got b=%h errb=%b bo=%h errbo=%b, want dead55ef 0 0 1",
               doutb_r, errb_r, doutb_o, errb_o);
    end
  endtask

  task automatic test_clear();
    int n;
    // Software clear with a dropped mid-fill write and an ignored repeat request.
    addra = mk_addr(1, 1); wea = 4'h0;
    clr_req = 1'b1; step(); clr_req = 1'b0;
    n = busy_r ? 1 : 0;
    for (int i = 0; i < 40 && busy_r; i++) begin
      wea = (i == 8) ? 4'hF : 4'h0; dina = 32'hCAFEF00D;
      clr_req = (i == 6);
      step();
      if (i == 8) begin
        checks++;
        if (douta_r !== 32'h0 || erra_r !== 1'b0) begin
          fails++;
          $display("FAIL busy_read: got %h err=%b, want 0 and 0", douta_r, erra_r);
        end
      end
      if (busy_r) n++;
    end
    wea = 4'h0; clr_req = 1'b0;
    checks++;
    if (n !== 16) begin
      fails++;
      $display("FAIL clr_req_fill_len: busy high %0d cycles, want 16", n);
    end
    step();
    checks++;
    if (douta_r !== 32'h0) begin
      fails++;
      $display("FAIL busy_write_dropped: word1=%h, want 0", douta_r);
    end
    // Reset five cycles into a fill restarts it from word 0.
    addra = mk_addr(1, 2); wea = 4'hF; dina = 32'h0BADCAFE; step();
    wea = 4'h0;
    clr_req = 1'b1; step(); clr_req = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1; step(); rst = 1'b0;
    n = busy_r ? 1 : 0;
    for (int i = 0; i < 40 && busy_r; i++) begin
      step();
      if (busy_r) n++;
    end
    checks++;
    if (n !== 16) begin
      fails++;
      $display("FAIL rst_restart_fill_len: busy high %0d cycles, want 16", n);
    end
    step();
    checks++;
    if (douta_r !== 32'h0 || mem_m[2] !== 32'h0) begin
      fails++;
      $display("FAIL rst_restart_cleared: word2=%h, want 0", douta_r);
    end
  endtask

  task automatic test_random();
    logic [200:0] act, exp;
    for (int c = 0; c < 400; c++) begin
      wea   = 4'($urandom);
      web   = 4'($urandom);
      dina  = $urandom;
      dinb  = $urandom;
      addra = mk_addr($urandom_range(0, 7) != 0, $urandom_range(0, 15));
      addrb = ($urandom_range(0, 3) == 0) ? addra :
              mk_addr($urandom_range(0, 7) != 0, $urandom_range(0, 15));
      clr_req = ($urandom_range(0, 79) == 0);
      step();
      act = {douta_r, douta_w, douta_o, doutb_r, doutb_w, doutb_o,
             erra_r, erra_w, erra_o, errb_r, errb_w, errb_o, busy_r, busy_w, busy_o};
      exp = {e1a_rf, e1a_wf, e2a, e1b_rf, e1b_wf, e2b,
             e1ea, e1ea, e2ea, e1eb, e1eb, e2eb, mbusy, mbusy, mbusy};
      checks++;
      if (act !== exp) begin
        fails++;
        $display("FAIL random_cycle_%0d: got %h want %h", c, act, exp);
      end
    end
    clr_req = 1'b0; wea = 4'h0; web = 4'h0;
  endtask

  initial begin
    test_reset();
    test_byte_write();
    test_collision();
    test_rdw();
    test_range();
    test_clear();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/dp_byte_ram_clr.md
Name: dp_byte_ram_clr

Overview:
- Parametrised successor to the CPU data RAM: a true dual-port synchronous RAM with per-byte write enables.
- Adds configurable width, depth and base address, selectable read-during-write mode, an optional output register, a defined same-word write-collision rule and a hardware zero-fill engine.
- Port A serves the CPU memory stage; port B serves the debug module.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8. NB = DATA_W/8 byte lanes.
- DEPTH_LOG2, 12, log2 of the word count. DEPTH = 2**DEPTH_LOG2.
- ADDR_W, 32, byte-address width. Ports carry word address bits [ADDR_W-1:OFF], with OFF = log2(NB).
- BASE, 0, value the address bits above DEPTH_LOG2+OFF must equal for an access to be in range.
- READ_MODE, 0, 0 = read-first (old data), 1 = write-first (same-port new data).
- OUT_REG, 0, 1 adds a second output register stage, raising read latency to 2.
- CLR_ON_RST, 1, 1 = zero-fill all words after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- clr_req  in  1  one-cycle pulse requesting a zero-fill.
- busy  out  1  zero-fill in progress.
- wea  in  NB  port A byte write enables.
- addra  in  ADDR_W-OFF  port A word address.
- dina  in  DATA_W  port A write data.
- douta  out  DATA_W  port A read data.
- erra  out  1  port A access out of range, registered, same latency as douta.
- web, addrb, dinb, doutb, errb  as port A, for port B.

Behaviour:
- Reset values: douta=0, doutb=0, erra=0, errb=0, all pipeline registers 0.
  - busy=1 from the cycle after rst when CLR_ON_RST=1; otherwise busy=0.
  - RAM contents are not reset.
- Range check: valid = (addr[ADDR_W-1:DEPTH_LOG2+OFF] == BASE); index = low DEPTH_LOG2 bits.
  - Invalid write: dropped.
  - Invalid read: returns 0 with err=1.
  - A write-only cycle to an invalid address still sets err=1.
- Read latency: data is sampled at edge N and appears after edge N+1 when OUT_REG=0, or after edge N+2 when OUT_REG=1. Reads occur every cycle (no enable).
- Byte write: lane i written when we[i] is set and the address is valid; other lanes keep their value.
- Same-port read-during-write:
  - READ_MODE=0: dout shows the old word.
  - READ_MODE=1: written lanes show new data, unwritten lanes show old data.
- Cross-port read of a word the other port writes in the same cycle: always returns the old word.
- Collision (both ports write the same valid index in the same cycle):
  - Overlapping lanes take port A data.
  - Lanes written by only one port take that port's data.
- FSM states: IDLE, CLEAR.
  - rst forces CLEAR (if CLR_ON_RST=1) or IDLE, with the counter at 0.
  - IDLE -> CLEAR on clr_req, counter reset to 0.
  - CLEAR writes word[counter]=0 each cycle, then counter+1. After index DEPTH-1 is written, the FSM goes to IDLE; busy drops on the following edge.
  - A full clear takes exactly DEPTH cycles of busy=1.
  - clr_req during CLEAR is ignored; the fill does not restart.
  - rst during CLEAR restarts the fill from word 0 (CLR_ON_RST=1) or aborts it (CLR_ON_RST=0).
- While busy=1:
  - Writes on both ports are dropped.
  - Reads return 0 with err=0.
  - This applies to requests sampled while busy=1; reads already in the pipeline complete normally.
- Counter width is DEPTH_LOG2+1 so the terminal condition is not lost to wrap-around.

Decomposition:
- Shared package dp_ram_pkg holds:
  - the state enum (IDLE/CLEAR);
  - the functions clog2 and lane_merge(old, new, be);
  - the constants RD_FIRST=0 and WR_FIRST=1.
- One natural sub-module, dp_ram_clr_fsm: the counter and FSM. It outputs busy, clr_we and clr_idx, which the top muxes onto port A's write path. The storage array stays in the top module so it infers as BRAM.

Test Plan:
- Reset with CLR_ON_RST=1, DEPTH_LOG2=4 -> busy high for 16 cycles then low; reading any of words 0..15 returns 0.
- Port A writes 0xDEADBEEF to word 3, then wea=4'b0010 with 0x00005500 -> read after 1 cycle = 0xDEAD55EF. With OUT_REG=1 the same value appears after 2 cycles.
- Both ports write word 5 in one cycle: A wea=0011 data 0x11112222, B web=0110 data 0x33334444 -> word = 0x00332222 (lanes 0-1 from A, lane 2 from B, lane 3 unchanged from cleared 0).
- Word 7 = 0xAAAAAAAA; port A writes 0x55555555 and reads word 7 in the same cycle:
  - READ_MODE=0 -> douta=0xAAAAAAAA;
  - READ_MODE=1 -> douta=0x55555555;
  - port B reading word 7 the same cycle -> 0xAAAAAAAA in both modes.
- Port B address with upper bits != BASE -> doutb=0 and errb=1 one cycle later; the write to that address is dropped and in-range memory is unchanged.
- clr_req, then rst asserted 5 cycles into the fill -> fill restarts at word 0; busy stays high for 16 cycles after rst deasserts; a port A write issued mid-fill is dropped.
